// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a memory watchdog
// and retired-instruction counter. Define ILLEGAL_TRAP_EN to trap unknown opcodes in HALT.
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8,
    parameter int RET_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             branch,
    output logic             mem_read,
    output logic             mem_to_reg,
    output logic [1:0]       alu_op,
    output logic             mem_write,
    output logic             alu_src,
    output logic             reg_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             mem_fault,
    output logic             illegal,
    output logic [RET_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_MATHI  = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_MATHR  = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic            TO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = (MEM_TIMEOUT != 0) ? TO_W'(MEM_TIMEOUT - 1) : '0;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [TO_W-1:0]   wd_r;
    logic [RET_W-1:0]  retired_r;
    logic              mem_fault_r;
    logic              retire_s;
    logic              abort_s;
    logic              wd_wait_s;
    logic              timeout_s;

    function automatic logic is_known(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_MATHI, OP_AUIPC, OP_STORE, OP_MATHR,
            OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: is_known = 1'b1;
            default:                            is_known = 1'b0;
        endcase
    endfunction

    assign timeout_s = TO_EN && (wd_r == TO_LAST);

    // State register, watchdog, retire counter and registered fault pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_FETCH;
            wd_r        <= '0;
            retired_r   <= '0;
            mem_fault_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            mem_fault_r <= abort_s;
            if (retire_s) begin
                retired_r <= retired_r + RET_W'(1);
            end else begin
                retired_r <= retired_r;
            end
            // FETCH->FETCH abort keeps the state, so the abort itself must clear the count
            if (abort_s || (state_nxt_s != state_r)) begin
                wd_r <= '0;
            end else if (wd_wait_s) begin
                wd_r <= wd_r + TO_W'(1);
            end else begin
                wd_r <= wd_r;
            end
        end
    end

    // Next-state and Moore strobe decode; reset forces every strobe low
    always_comb begin
        state_nxt_s = state_r;
        retire_s    = 1'b0;
        abort_s     = 1'b0;
        wd_wait_s   = 1'b0;
        branch      = 1'b0;
        mem_read    = 1'b0;
        mem_to_reg  = 1'b0;
        alu_op      = 2'b00;
        mem_write   = 1'b0;
        alu_src     = 1'b0;
        reg_write   = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        mem_fault   = 1'b0;
        illegal     = 1'b0;
        if (rst) begin
            state_nxt_s = S_FETCH;
        end else begin
            mem_fault = mem_fault_r;
            case (state_r)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    wd_wait_s = TO_EN && !mem_ready;
                    if (mem_ready) begin
                        ir_write    = 1'b1;
                        pc_write    = 1'b1;
                        state_nxt_s = S_DECODE;
                    end else if (timeout_s) begin
                        abort_s     = 1'b1;
                        state_nxt_s = S_FETCH;
                    end else begin
                        state_nxt_s = S_FETCH;
                    end
                end
                S_DECODE: begin
                    if (is_known(opcode)) begin
                        state_nxt_s = S_EXEC;
                    end else begin
`ifdef ILLEGAL_TRAP_EN
                        state_nxt_s = S_HALT;
`else
                        state_nxt_s = S_FETCH;
                        retire_s    = 1'b1;
`endif
                    end
                end
                S_EXEC: begin
                    case (opcode)
                        OP_LOAD, OP_STORE: begin
                            alu_src     = 1'b1;
                            alu_op      = 2'b00;
                            state_nxt_s = S_MEM;
                        end
                        OP_MATHI: begin
                            alu_op      = 2'b11;
                            alu_src     = 1'b1;
                            state_nxt_s = S_WB;
                        end
                        OP_MATHR: begin
                            alu_op      = 2'b10;
                            state_nxt_s = S_WB;
                        end
                        OP_BRANCH: begin
                            branch      = 1'b1;
                            alu_op      = 2'b01;
                            pc_write    = 1'b1;
                            retire_s    = 1'b1;
                            state_nxt_s = S_FETCH;
                        end
                        OP_JAL, OP_JALR: begin
                            pc_write    = 1'b1;
                            state_nxt_s = S_WB;
                        end
                        OP_AUIPC, OP_LUI: begin
                            state_nxt_s = S_WB;
                        end
                        default: begin
                            state_nxt_s = S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    wd_wait_s = TO_EN && !mem_ready;
                    if (opcode == OP_STORE) begin
                        mem_write = 1'b1;
                    end else begin
                        mem_read   = 1'b1;
                        mem_to_reg = 1'b1;
                    end
                    if (mem_ready) begin
                        if (opcode == OP_STORE) begin
                            retire_s    = 1'b1;
                            state_nxt_s = S_FETCH;
                        end else begin
                            state_nxt_s = S_WB;
                        end
                    end else if (timeout_s) begin
                        abort_s     = 1'b1;
                        state_nxt_s = S_FETCH;
                    end else begin
                        state_nxt_s = S_MEM;
                    end
                end
                S_WB: begin
                    reg_write   = 1'b1;
                    mem_to_reg  = (opcode == OP_LOAD);
                    retire_s    = 1'b1;
                    state_nxt_s = S_FETCH;
                end
                S_HALT: begin
`ifdef ILLEGAL_TRAP_EN
                    illegal     = 1'b1;
                    state_nxt_s = S_HALT;
`else
                    state_nxt_s = S_FETCH;
`endif
                end
                default: begin
                    state_nxt_s = S_FETCH;
                end
            endcase
        end
    end

    assign retired = retired_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Table-driven, cycle-by-cycle bench for multicycle_control_unit (MEM_TIMEOUT=4, RET_W=4).
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
    logic       ir_write, pc_write, mem_fault, illegal;
    logic [1:0] alu_op;
    logic [3:0] retired;

    multicycle_control_unit #(.MEM_TIMEOUT(4), .TO_W(8), .RET_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .branch(branch), .mem_read(mem_read), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
        .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write), .ir_write(ir_write),
        .pc_write(pc_write), .mem_fault(mem_fault), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LOAD = 7'b0000011, MATHI = 7'b0010011, AUIPC = 7'b0010111;
    localparam logic [6:0] STORE = 7'b0100011, MATHR = 7'b0110011, LUI = 7'b0110111;
    localparam logic [6:0] BRANCH = 7'b1100011, JALR = 7'b1100111, JAL = 7'b1101111;
    localparam logic [6:0] BAD = 7'b0000000;

    // bundle: {illegal, branch, mem_read, mem_to_reg, alu_op[1:0], mem_write, alu_src,
    //          reg_write, ir_write, pc_write, mem_fault}
    localparam logic [11:0] NONE   = 12'h000;
    localparam logic [11:0] F_WAIT = 12'h200;
    localparam logic [11:0] F_RDY  = 12'h206;
    localparam logic [11:0] FAULT  = 12'h001;
    localparam logic [11:0] EX_LS  = 12'h010;
    localparam logic [11:0] EX_MI  = 12'h0D0;
    localparam logic [11:0] EX_MR  = 12'h080;
    localparam logic [11:0] EX_BR  = 12'h442;
    localparam logic [11:0] EX_J   = 12'h002;
    localparam logic [11:0] MEM_LD = 12'h300;
    localparam logic [11:0] MEM_ST = 12'h020;
    localparam logic [11:0] WB_LD  = 12'h108;
    localparam logic [11:0] WB_R   = 12'h008;
    localparam logic [11:0] HALTED = 12'h800;

    typedef struct {
        logic       r;
        logic [6:0] op;
        logic       rdy;
        logic [11:0] exp;
        logic [3:0] ret;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] sb[$];
    logic [3:0]  ret_m;
    logic [15:0] want;
    logic [15:0] got;
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic add(input logic r, input logic [6:0] op, input logic rdy, input logic [11:0] e);
        vec_t v;
        v.r = r; v.op = op; v.rdy = rdy; v.exp = e; v.ret = ret_m;
        vecs.push_back(v);
    endtask

    // zero-wait four-cycle instruction: FETCH, DECODE, EXEC, WB
    task automatic four(input logic [6:0] op, input logic [11:0] ex);
        add(1'b0, op, 1'b1, F_RDY);
        add(1'b0, op, 1'b1, NONE);
        add(1'b0, op, 1'b1, ex);
        add(1'b0, op, 1'b1, WB_R);
        ret_m = ret_m + 4'd1;
    endtask

    task automatic check(input logic ok, input string what, input int idx);
        if (!ok) begin
            n_bad++;
            $display("FAIL vec%0d (%s): strobes=%h retired=%0d, expected strobes=%h retired=%0d",
                     idx, what, got[15:4], got[3:0], want[15:4], want[3:0]);
        end
    endtask

    initial begin
        ret_m = 4'd0;
        add(1'b1, MATHR, 1'b1, NONE);
        add(1'b1, MATHR, 1'b1, NONE);
        four(MATHR, EX_MR);

        // LOAD with three wait cycles; ready lands on the watchdog's last count and wins
        add(1'b0, LOAD, 1'b1, F_RDY);
        add(1'b0, LOAD, 1'b1, NONE);
        add(1'b0, LOAD, 1'b1, EX_LS);
        for (int i = 0; i < 3; i++) add(1'b0, LOAD, 1'b0, MEM_LD);
        add(1'b0, LOAD, 1'b1, MEM_LD);
        add(1'b0, LOAD, 1'b1, WB_LD);
        ret_m = ret_m + 4'd1;

        // STORE never acknowledged: four write cycles then abort, no retire
        add(1'b0, STORE, 1'b1, F_RDY);
        add(1'b0, STORE, 1'b1, NONE);
        add(1'b0, STORE, 1'b1, EX_LS);
        for (int i = 0; i < 4; i++) add(1'b0, STORE, 1'b0, MEM_ST);
        add(1'b0, STORE, 1'b0, F_WAIT | FAULT);
        for (int i = 0; i < 3; i++) add(1'b0, STORE, 1'b0, F_WAIT);

        // FETCH timeout fault pulse coincides with the next fetch completing
        add(1'b0, STORE, 1'b1, F_RDY | FAULT);
        add(1'b0, STORE, 1'b1, NONE);
        add(1'b0, STORE, 1'b1, EX_LS);
        add(1'b0, STORE, 1'b1, MEM_ST);
        ret_m = ret_m + 4'd1;

        add(1'b0, BRANCH, 1'b1, F_RDY);
        add(1'b0, BRANCH, 1'b1, NONE);
        add(1'b0, BRANCH, 1'b1, EX_BR);
        ret_m = ret_m + 4'd1;

        add(1'b0, BAD, 1'b1, F_RDY);
        add(1'b0, BAD, 1'b1, NONE);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) add(1'b0, BAD, 1'b1, HALTED);
        add(1'b1, BAD, 1'b1, NONE);
        ret_m = 4'd0;
`else
        ret_m = ret_m + 4'd1;
`endif

        four(JAL, EX_J);
        four(JALR, EX_J);
        four(LUI, NONE);
        four(AUIPC, NONE);
        for (int k = 0; k < 16; k++) four(MATHI, EX_MI);

        // reset during EXEC: no WB, counter cleared
        add(1'b0, MATHR, 1'b1, F_RDY);
        add(1'b0, MATHR, 1'b1, NONE);
        add(1'b1, MATHR, 1'b1, NONE);
        ret_m = 4'd0;
        four(MATHR, EX_MR);
        add(1'b0, MATHR, 1'b1, F_RDY);

        rst       = 1'b1;
        opcode    = MATHR;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            rst       = vecs[i].r;
            opcode    = vecs[i].op;
            mem_ready = vecs[i].rdy;
            sb.push_back({vecs[i].exp, vecs[i].ret});
            @(negedge clk);
            want = sb.pop_front();
            got  = {illegal, branch, mem_read, mem_to_reg, alu_op, mem_write, alu_src,
                    reg_write, ir_write, pc_write, mem_fault, retired};
            n_vec++;
            check(got === want, "table", i);
            if (vecs[i].r) begin
                check(got[15:4] === 12'h000, "reset-state strobes", i);
            end
            if (want[4]) begin
                check((mem_fault === 1'b1) && (reg_write === 1'b0), "expired-wait fault", i);
            end
            @(posedge clk);
            #1;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle RV32I main decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives per-state datapath strobes.
- Waits on a variable-latency memory handshake, with a watchdog on every memory wait.
- Keeps a retired-instruction counter. Sits between the instruction register and the datapath/ALU control.

Parameters:
- MEM_TIMEOUT, 255: max cycles waiting on mem_ready in FETCH or MEM before abort; 0 = watchdog disabled.
- TO_W, 8: width of the watchdog counter; must hold MEM_TIMEOUT.
- RET_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- opcode  in  7  instr[6:0] from instruction register; valid from DECODE onward
- mem_ready  in  1  memory completes current read/write this cycle
- branch  out  1  branch compare/PC select strobe
- mem_read  out  1  memory read request
- mem_to_reg  out  1  writeback source = memory data
- alu_op  out  2  00 add, 01 branch, 10 R-type, 11 I-type
- mem_write  out  1  memory write request
- alu_src  out  1  ALU B operand = immediate
- reg_write  out  1  register-file write enable
- ir_write  out  1  latch fetched instruction
- pc_write  out  1  update PC
- mem_fault  out  1  one-cycle pulse on watchdog abort
- illegal  out  1  illegal-opcode flag (see Optional Feature)
- retired  out  RET_W  count of completed instructions

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - state = FETCH, watchdog = 0, retired = 0.
  - All strobes 0, illegal = 0. Reset mid-instruction aborts it with no write issued.
- Outputs are Moore: decoded from state plus the opcode held in the IR. Unlisted strobes are 0.
- Opcode encodings:
  - LOAD 0000011, MATHI 0010011, AUIPC 0010111, STORE 0100011, MATHR 0110011
  - LUI 0110111, BRANCH 1100011, JALR 1100111, JAL 1101111
- FETCH:
  - mem_read = 1. Hold the state until mem_ready = 1.
  - In the mem_ready cycle: ir_write = 1, pc_write = 1, then go to DECODE.
- DECODE: one cycle, no strobes.
  - Known opcode -> EXEC.
  - Unknown opcode -> see Optional Feature.
- EXEC: one cycle.
  - LOAD/STORE: alu_src = 1, alu_op = 00 -> MEM.
  - MATHI: alu_op = 11, alu_src = 1 -> WB.
  - MATHR: alu_op = 10 -> WB.
  - BRANCH: branch = 1, alu_op = 01, pc_write = 1 -> FETCH; retires.
  - AUIPC/LUI/JAL/JALR -> WB. JAL/JALR also assert pc_write in EXEC.
- MEM:
  - LOAD: mem_read = 1, mem_to_reg = 1. STORE: mem_write = 1.
  - Hold the state until mem_ready.
  - LOAD -> WB. STORE -> FETCH; retires.
- WB: one cycle, reg_write = 1; mem_to_reg = 1 for LOAD. Then -> FETCH; retires.
- Retire: retired increments by 1 on the cycle leaving the final state. It wraps modulo 2^RET_W with no flag.
- Watchdog:
  - Counts cycles in FETCH/MEM while mem_ready = 0; cleared on any state change.
  - If MEM_TIMEOUT != 0 and the count reaches MEM_TIMEOUT-1 with mem_ready still 0:
    - Next cycle: mem_fault = 1 for one cycle, state = FETCH.
    - No reg_write or retire; the counter clears.
  - If mem_ready arrives on the same cycle as the timeout, mem_ready wins and there is no fault.
- Strobe rules:
  - mem_read and mem_write are never both 1.
  - reg_write is never 1 outside WB.
- Throughput:
  - With zero-wait memory (mem_ready tied 1): LOAD 5 cycles; MATHx/LUI/AUIPC/JAL/JALR 4; STORE 4; BRANCH 3.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE moves to HALT.
  - HALT sets illegal = 1, all strobes 0, retired frozen.
  - Held until rst.
- Undefined: an unknown opcode in DECODE goes directly to FETCH as a NOP and counts as retired.
  - illegal is tied 0.

Test Plan:
- rst=1 two cycles, release, mem_ready=1, opcode=0110011 -> strobes 0 during reset; FETCH mem_read/ir_write/pc_write, DECODE, EXEC alu_op=10, WB reg_write=1; retired=1 after 4 cycles.
- LOAD 0000011 with mem_ready low 3 cycles in MEM -> mem_read held 4 cycles, then WB with reg_write=1 and mem_to_reg=1; total 8 cycles; retired +1.
- MEM_TIMEOUT=4, STORE 0100011, mem_ready=0 in MEM -> mem_write for 4 cycles, mem_fault pulse, back to FETCH, retired unchanged.
- BRANCH 1100011 -> EXEC branch=1, alu_op=01, pc_write=1; no reg_write; 3 cycles; retired +1.
- opcode 0000000 -> with ILLEGAL_TRAP_EN: illegal=1 stuck, outputs 0 until rst. Without it: NOP, retired +1.
- RET_W=4, 16 MATHI instructions -> retired wraps 15->0; rst asserted mid-EXEC -> FETCH next cycle, no reg_write.
